// File: rtl/bram_dot_pkg.sv
// Shared types and constants for the BRAM int8 dot-product engine.
package bram_dot_pkg;

    localparam int unsigned LANES       = 4;
    localparam int unsigned LANE_W      = 8;
    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned MAX_VEC_LEN = 2048;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StDrain,
        StWrite,
        StDone
    } state_e;

    typedef enum logic {
        TAG_A = 1'b0,
        TAG_B = 1'b1
    } tag_e;

    typedef struct packed {
        logic valid;
        tag_e tag;
    } tag_t;

endpackage

// File: rtl/bram_dot_lane_mac.sv
// Combinational 4-lane signed int8 multiply with an 18-bit lane sum,
// sign-extended to 32 bits.
module bram_dot_lane_mac
    import bram_dot_pkg::*;
(
    input  logic [31:0] a_word_i,
    input  logic [31:0] b_word_i,
    output logic [31:0] dot_o
);

    logic signed [15:0] prod [LANES];
    logic signed [17:0] lane_sum;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod[i] = 16'($signed(a_word_i[i*LANE_W +: LANE_W])) *
                      16'($signed(b_word_i[i*LANE_W +: LANE_W]));
        end
    end

    always_comb begin
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + 18'(prod[i]);
        end
        dot_o = 32'(lane_sum);
    end

endmodule

// File: rtl/bram_dot_engine.sv
// BRAM master that streams int8 vectors A and B, accumulates their dot product and writes it back.
// Define BRAM_DOT_RELU_EN to clamp the written/latched result at zero.
module bram_dot_engine
    import bram_dot_pkg::*;
#(
    parameter int unsigned BRAM_ADDR_WIDTH = 15,
    parameter int unsigned VEC_LEN         = 64,
    parameter int unsigned A_BASE          = 0,
    parameter int unsigned B_BASE          = 256,
    parameter int unsigned OUT_ADDR        = 512,
    parameter int unsigned RD_LATENCY      = 2
) (
    input  logic                       BRAM_CLK,
    input  logic                       BRAM_RST,
    input  logic                       start,
    output logic [BRAM_ADDR_WIDTH-1:0] MEM_ADDR,
    output logic                       MEM_EN,
    output logic [3:0]                 MEM_WE,
    output logic [31:0]                MEM_WRDATA,
    input  logic [31:0]                MEM_RDDATA,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                result
);

    if (VEC_LEN == 0 || VEC_LEN > MAX_VEC_LEN) begin : g_vec_len_check
        $error("bram_dot_engine: VEC_LEN must be in 1..2048");
    end
    if (RD_LATENCY == 0) begin : g_rd_latency_check
        $error("bram_dot_engine: RD_LATENCY must be at least 1");
    end

    localparam int unsigned CNT_W = $clog2(2 * VEC_LEN + RD_LATENCY) + 1;
    localparam logic [CNT_W-1:0] ISSUE_LAST = CNT_W'(2 * VEC_LEN - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(RD_LATENCY - 1);
    localparam logic [BRAM_ADDR_WIDTH-1:0] A_BASE_W = BRAM_ADDR_WIDTH'(A_BASE);
    localparam logic [BRAM_ADDR_WIDTH-1:0] B_BASE_W = BRAM_ADDR_WIDTH'(B_BASE);
    localparam logic [BRAM_ADDR_WIDTH-1:0] OUT_W    = BRAM_ADDR_WIDTH'(OUT_ADDR);
    localparam logic [BRAM_ADDR_WIDTH-1:0] LAST_B_W =
        BRAM_ADDR_WIDTH'(B_BASE + WORD_BYTES * (VEC_LEN - 1));

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    tag_t                       tag_q [RD_LATENCY];
    tag_t                       tag_d [RD_LATENCY];
    logic [31:0]                acc_q, acc_d;
    logic [31:0]                a_hold_q, a_hold_d;
    logic [31:0]                result_q, result_d;
    logic [31:0]                lane_dot;
    logic [31:0]                wr_val;
    logic [BRAM_ADDR_WIDTH-1:0] word_off;

    bram_dot_lane_mac u_lane_mac (
        .a_word_i (a_hold_q),
        .b_word_i (MEM_RDDATA),
        .dot_o    (lane_dot)
    );

`ifdef BRAM_DOT_RELU_EN
    assign wr_val = acc_q[31] ? 32'h0 : acc_q;
`else
    assign wr_val = acc_q;
`endif

    // Each A/B pair shares one word offset: index k maps to word k/2.
    assign word_off = BRAM_ADDR_WIDTH'(cnt_q[CNT_W-1:1]) << 2;
    assign result   = result_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        a_hold_d   = a_hold_q;
        result_d   = result_q;
        tag_d[0]   = '0;
        MEM_ADDR   = '0;
        MEM_EN     = 1'b0;
        MEM_WE     = 4'h0;
        MEM_WRDATA = 32'h0;
        busy       = 1'b0;
        done       = 1'b0;

        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end

        if (tag_q[RD_LATENCY-1].valid) begin
            if (tag_q[RD_LATENCY-1].tag == TAG_B) begin
                acc_d = acc_q + lane_dot;
            end else begin
                a_hold_d = MEM_RDDATA;
            end
        end

        unique case (state_q)
            StIdle, StDone: begin
                done = (state_q == StDone);
                if (start) begin
                    state_d = StIssue;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
            StIssue: begin
                busy           = 1'b1;
                MEM_EN         = 1'b1;
                MEM_ADDR       = (cnt_q[0] ? B_BASE_W : A_BASE_W) + word_off;
                tag_d[0].valid = 1'b1;
                tag_d[0].tag   = cnt_q[0] ? TAG_B : TAG_A;
                if (cnt_q == ISSUE_LAST) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDrain: begin
                // Enable stays high so the BRAM output register keeps advancing.
                busy     = 1'b1;
                MEM_EN   = 1'b1;
                MEM_ADDR = LAST_B_W;
                if (cnt_q == DRAIN_LAST) begin
                    state_d = StWrite;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StWrite: begin
                busy       = 1'b1;
                MEM_EN     = 1'b1;
                MEM_ADDR   = OUT_W;
                MEM_WE     = 4'hF;
                MEM_WRDATA = wr_val;
                result_d   = wr_val;
                state_d    = StDone;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge BRAM_CLK or posedge BRAM_RST) begin
        if (BRAM_RST) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            a_hold_q <= '0;
            result_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_hold_q <= a_hold_d;
            result_q <= result_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_d[i];
            end
        end
    end

endmodule

// File: tb/tb_bram_dot_engine.sv
// Self-checking bench: three engines (VEC_LEN 64, 1, 2048) each on a behavioural 2-cycle BRAM.
module tb_bram_dot_engine;

    localparam int AW = 15;
    localparam int MW = 8192;
    localparam int N0 = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    start;
    logic [AW-1:0] mem_addr   [3];
    logic [2:0]    mem_en;
    logic [3:0]    mem_we     [3];
    logic [31:0]   mem_wrdata [3];
    logic [31:0]   mem_rddata [3];
    logic [31:0]   result     [3];
    logic [2:0]    busy;
    logic [2:0]    done;

    logic [31:0]   mem [3][MW];
    int            wcnt  [3];
    logic [31:0]   wdata [3];
    logic [AW-1:0] waddr [3];

    logic [31:0]   va[$];
    logic [31:0]   vb[$];
    int            nchecks = 0;
    int            nerr    = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned LEN = (g == 0) ? 64 : (g == 1) ? 1 : 2048;
        localparam int unsigned BB  = (g == 2) ? 8192 : 256;
        localparam int unsigned OA  = (g == 2) ? 16384 : 512;
        logic [AW-1:0] areg;
        logic [31:0]   rq;
        int            cnt = 0;
        logic [31:0]   wd;
        logic [AW-1:0] wa;

        bram_dot_engine #(
            .BRAM_ADDR_WIDTH (AW),
            .VEC_LEN         (LEN),
            .A_BASE          (0),
            .B_BASE          (BB),
            .OUT_ADDR        (OA),
            .RD_LATENCY      (2)
        ) u_dut (
            .BRAM_CLK   (clk),
            .BRAM_RST   (rst),
            .start      (start[g]),
            .MEM_ADDR   (mem_addr[g]),
            .MEM_EN     (mem_en[g]),
            .MEM_WE     (mem_we[g]),
            .MEM_WRDATA (mem_wrdata[g]),
            .MEM_RDDATA (mem_rddata[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .result     (result[g])
        );

        // Address register then output register, both gated by enable.
        always @(posedge clk) begin
            if (mem_en[g]) begin
                areg <= mem_addr[g];
                rq   <= mem[g][areg[AW-1:2]];
            end
            if (mem_en[g] && mem_we[g] != 4'h0) begin
                cnt <= cnt + 1;
                wd  <= mem_wrdata[g];
                wa  <= mem_addr[g];
            end
        end

        assign mem_rddata[g] = rq;
        assign wcnt[g]       = cnt;
        assign wdata[g]      = wd;
        assign waddr[g]      = wa;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not reach its summary");
        $fatal(1);
    end

    function automatic logic [31:0] ref_dot(input int n);
        int          acc = 0;
        logic [31:0] aw, bw;
        byte         sa, sb;
        for (int w = 0; w < n; w++) begin
            aw = va[w];
            bw = vb[w];
            for (int l = 0; l < 4; l++) begin
                sa = aw[8*l +: 8];
                sb = bw[8*l +: 8];
                acc += int'(sa) * int'(sb);
            end
        end
`ifdef BRAM_DOT_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    task automatic make_vec(input int n, input bit rnd, input logic [31:0] a, input logic [31:0] b);
        va.delete();
        vb.delete();
        for (int w = 0; w < n; w++) begin
            va.push_back(rnd ? $urandom() : a);
            vb.push_back(rnd ? $urandom() : b);
        end
    endtask

    task automatic fill(input int g, input int bword);
        for (int w = 0; w < va.size(); w++) begin
            mem[g][w]         = va[w];
            mem[g][bword + w] = vb[w];
        end
    endtask

    // Runs engine 0 once and reports how its cycle-by-cycle behaviour deviated.
    task automatic run_trace(output int bad_issue, output int bad_drain, output int bad_write,
                             output logic [31:0] wr_at, output int first_done,
                             output int nwr, output logic [31:0] res);
        int w0 = wcnt[0];
        int exp_addr;
        bad_issue  = 0;
        bad_drain  = 0;
        bad_write  = 0;
        wr_at      = 32'hx;
        first_done = -1;
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        for (int c = 0; c < 2 * N0 + 6; c++) begin
            @(negedge clk);
            if (c < 2 * N0) begin
                exp_addr = (c % 2 == 0) ? 4 * (c / 2) : 256 + 4 * (c / 2);
                if (!(mem_en[0] === 1'b1 && mem_we[0] === 4'h0 && mem_addr[0] === AW'(exp_addr)
                      && busy[0] === 1'b1 && done[0] === 1'b0)) bad_issue++;
            end else if (c < 2 * N0 + 2) begin
                if (!(mem_en[0] === 1'b1 && mem_we[0] === 4'h0
                      && mem_addr[0] === AW'(256 + 4 * (N0 - 1)) && busy[0] === 1'b1)) bad_drain++;
            end else if (c == 2 * N0 + 2) begin
                wr_at = mem_wrdata[0];
                if (!(mem_en[0] === 1'b1 && mem_we[0] === 4'hF && mem_addr[0] === AW'(512)
                      && busy[0] === 1'b1 && done[0] === 1'b0)) bad_write++;
            end else if (mem_en[0] !== 1'b0 || busy[0] !== 1'b0) begin
                bad_write++;
            end
            if (done[0] === 1'b1 && first_done < 0) first_done = c;
        end
        nwr = wcnt[0] - w0;
        res = result[0];
    endtask

    task automatic run_simple(input int g, input int len, output int lat, output int nwr,
                              output logic [31:0] res, output logic [31:0] wd,
                              output logic [AW-1:0] wa);
        int w0 = wcnt[g];
        lat = -1;
        @(posedge clk); #1 start[g] = 1'b1;
        @(posedge clk); #1 start[g] = 1'b0;
        for (int c = 0; c < 2 * len + 20; c++) begin
            @(negedge clk);
            if (done[g] === 1'b1) begin
                lat = c;
                break;
            end
        end
        nwr = wcnt[g] - w0;
        res = result[g];
        wd  = wdata[g];
        wa  = waddr[g];
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            nchecks++;
            if (mem_en[g] !== 1'b0 || mem_we[g] !== 4'h0 || mem_addr[g] !== '0
                || mem_wrdata[g] !== 32'h0) begin
                nerr++;
                $display("FAIL reset_mem_if[%0d]: got en=%b we=%h addr=%h wd=%h required all 0",
                         g, mem_en[g], mem_we[g], mem_addr[g], mem_wrdata[g]);
            end
            nchecks++;
            if (busy[g] !== 1'b0 || done[g] !== 1'b0 || result[g] !== 32'h0) begin
                nerr++;
                $display("FAIL reset_status[%0d]: got busy=%b done=%b result=%h required 0/0/0",
                         g, busy[g], done[g], result[g]);
            end
        end
        rst = 1'b0;
    endtask

    task automatic check_trace(input string name, input logic [31:0] exp);
        int bi, bd, bw, fd, nwr;
        logic [31:0] wr_at, res;
        run_trace(bi, bd, bw, wr_at, fd, nwr, res);
        nchecks++;
        if (bi !== 0) begin
            nerr++; $display("FAIL %s_issue: %0d bad ISSUE cycles, required 0", name, bi);
        end
        nchecks++;
        if (bd !== 0) begin
            nerr++; $display("FAIL %s_drain: %0d bad DRAIN cycles, required 0", name, bd);
        end
        nchecks++;
        if (bw !== 0) begin
            nerr++; $display("FAIL %s_write_cycle: %0d bad WRITE/DONE cycles, required 0", name, bw);
        end
        nchecks++;
        if (wr_at !== exp) begin
            nerr++; $display("FAIL %s_wrdata: got %h required %h", name, wr_at, exp);
        end
        nchecks++;
        if (fd !== 2 * N0 + 3) begin
            nerr++; $display("FAIL %s_done_cycle: got %0d required %0d", name, fd, 2 * N0 + 3);
        end
        nchecks++;
        if (nwr !== 1) begin
            nerr++; $display("FAIL %s_write_count: got %0d required 1", name, nwr);
        end
        nchecks++;
        if (res !== exp) begin
            nerr++; $display("FAIL %s_result: got %h required %h", name, res, exp);
        end
    endtask

    task automatic test_basic();
        make_vec(N0, 1'b0, 32'h01010101, 32'h02020202);
        fill(0, 64);
        check_trace("basic", 32'h00000200);
    endtask

    task automatic test_random();
        for (int i = 0; i < 3; i++) begin
            make_vec(N0, 1'b1, 32'h0, 32'h0);
            fill(0, 64);
            check_trace("random", ref_dot(N0));
        end
    endtask

    task automatic test_len1();
        int lat, nwr;
        logic [31:0] res, wd, exp;
        logic [AW-1:0] wa;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) begin
                make_vec(1, 1'b0, 32'hFF7F8001, 32'h01020304);
`ifdef BRAM_DOT_RELU_EN
                exp = 32'h00000000;
`else
                exp = 32'hFFFFFF81;
`endif
            end else begin
                make_vec(1, 1'b1, 32'h0, 32'h0);
                exp = ref_dot(1);
            end
            fill(1, 64);
            run_simple(1, 1, lat, nwr, res, wd, wa);
            nchecks++;
            if (lat !== 5) begin
                nerr++; $display("FAIL len1_done_cycle: got %0d required 5", lat);
            end
            nchecks++;
            if (nwr !== 1 || wa !== AW'(512)) begin
                nerr++; $display("FAIL len1_write: got count=%0d addr=%h required 1/200", nwr, wa);
            end
            nchecks++;
            if (wd !== exp || res !== exp) begin
                nerr++; $display("FAIL len1_result: got wr=%h result=%h required %h", wd, res, exp);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int w0;
        make_vec(N0, 1'b0, 32'h01010101, 32'h02020202);
        fill(0, 64);
        w0 = wcnt[0];
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk); #1 start[0] = 1'b0;
        repeat (11) @(negedge clk);
        nchecks++;
        if (mem_en[0] !== 1'b1 || mem_addr[0] !== AW'(20)) begin
            nerr++; $display("FAIL rst_pre_addr: got en=%b addr=%h required 1/014", mem_en[0], mem_addr[0]);
        end
        rst = 1'b1;
        #1;
        nchecks++;
        if (mem_en[0] !== 1'b0 || mem_we[0] !== 4'h0 || mem_addr[0] !== '0 || busy[0] !== 1'b0
            || done[0] !== 1'b0 || result[0] !== 32'h0) begin
            nerr++;
            $display("FAIL rst_midrun_outputs: got en=%b we=%h addr=%h busy=%b done=%b res=%h required 0",
                     mem_en[0], mem_we[0], mem_addr[0], busy[0], done[0], result[0]);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (8) @(negedge clk);
        nchecks++;
        if (wcnt[0] - w0 !== 0 || busy[0] !== 1'b0 || done[0] !== 1'b0) begin
            nerr++;
            $display("FAIL rst_no_write: got writes=%0d busy=%b done=%b required 0/0/0",
                     wcnt[0] - w0, busy[0], done[0]);
        end
        check_trace("rst_restart", 32'h00000200);
    endtask

    task automatic test_back_to_back();
        int w0, ndone, cur_busy, cur_done, excl_bad, bad_len, bad_res;
        int busy_runs[$];
        int done_runs[$];
        logic [31:0] res_q[$];
        logic prev_done;
        logic [31:0] exp;
        make_vec(N0, 1'b1, 32'h0, 32'h0);
        fill(0, 64);
        exp = ref_dot(N0);
        w0 = wcnt[0];
        ndone = 0; cur_busy = 0; cur_done = 0; excl_bad = 0; prev_done = 1'b0;
        @(posedge clk); #1 start[0] = 1'b1;
        @(posedge clk);
        for (int c = 0; c < 3 * (2 * N0 + 8); c++) begin
            @(negedge clk);
            if (busy[0] === done[0]) excl_bad++;
            if (busy[0] === 1'b1) cur_busy++;
            else if (cur_busy > 0) begin busy_runs.push_back(cur_busy); cur_busy = 0; end
            if (done[0] === 1'b1) begin
                cur_done++;
                if (!prev_done) begin ndone++; res_q.push_back(result[0]); end
            end else if (cur_done > 0) begin
                done_runs.push_back(cur_done); cur_done = 0;
            end
            prev_done = done[0];
            if (ndone == 3) break;
        end
        start[0] = 1'b0;
        bad_len = 0;
        bad_res = 0;
        foreach (busy_runs[i]) if (busy_runs[i] != 2 * N0 + 3) bad_len++;
        foreach (done_runs[i]) if (done_runs[i] != 1) bad_len++;
        foreach (res_q[i]) if (res_q[i] !== exp) bad_res++;
        nchecks++;
        if (ndone !== 3 || busy_runs.size() !== 3 || done_runs.size() !== 2) begin
            nerr++;
            $display("FAIL b2b_runs: got done_rises=%0d busy_runs=%0d done_gaps=%0d required 3/3/2",
                     ndone, busy_runs.size(), done_runs.size());
        end
        nchecks++;
        if (bad_len !== 0 || excl_bad !== 0) begin
            nerr++;
            $display("FAIL b2b_spans: got bad_lengths=%0d overlap_cycles=%0d required 0/0", bad_len, excl_bad);
        end
        nchecks++;
        if (bad_res !== 0) begin
            nerr++; $display("FAIL b2b_results: got %0d wrong results required 0 (exp %h)", bad_res, exp);
        end
        @(negedge clk);
        nchecks++;
        if (wcnt[0] - w0 !== 3) begin
            nerr++; $display("FAIL b2b_write_count: got %0d required 3", wcnt[0] - w0);
        end
    endtask

    task automatic test_long();
        int lat, nwr;
        logic [31:0] res, wd;
        logic [AW-1:0] wa;
        make_vec(2048, 1'b0, 32'h80808080, 32'h80808080);
        fill(2, 2048);
        run_simple(2, 2048, lat, nwr, res, wd, wa);
        nchecks++;
        if (lat !== 2 * 2048 + 3) begin
            nerr++; $display("FAIL long_done_cycle: got %0d required %0d", lat, 2 * 2048 + 3);
        end
        nchecks++;
        if (nwr !== 1 || wa !== AW'(16384)) begin
            nerr++; $display("FAIL long_write: got count=%0d addr=%h required 1/4000", nwr, wa);
        end
        nchecks++;
        if (wd !== 32'h08000000 || res !== 32'h08000000) begin
            nerr++; $display("FAIL long_result: got wr=%h result=%h required 08000000", wd, res);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 3'b000;
        for (int g = 0; g < 3; g++) begin
            for (int i = 0; i < MW; i++) mem[g][i] = 32'h0;
        end
        test_reset();
        test_basic();
        test_random();
        test_len1();
        test_reset_midrun();
        test_back_to_back();
        test_long();
        $display("CHECKS %0d ERRORS %0d", nchecks, nerr);
        $finish;
    end

endmodule
